// File: rtl/jtpang_pkg.sv
// Shared definitions for the object DMA: FSM encoding and object table geometry.
package jtpang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_COPY  = 2'd2,
    ST_FLUSH = 2'd3
  } dma_state_t;

  localparam int unsigned OBJ_TABLE_AW = 9;
  localparam logic [11:0] OBJ_SRC_BASE = 12'h000;

endpackage

// File: rtl/jtpang_objdma_edge.sv
// cpu_cen-gated rising-edge detector on dma_go plus a one-deep pending request latch.
module jtpang_objdma_edge (
  input  logic rst,
  input  logic clk,
  input  logic cpu_cen,
  input  logic dma_go,
  input  logic busy,
  input  logic clr,
  output logic go_edge_c,
  output logic pending
);

  logic go_q;

  assign go_edge_c = dma_go & ~go_q;

  // Edges arriving while a transfer is in flight merge into a single pending request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q    <= 1'b0;
      pending <= 1'b0;
    end else if (cpu_cen) begin
      go_q <= dma_go;
      if (go_edge_c && busy) pending <= 1'b1;
      else if (clr)          pending <= 1'b0;
    end
  end

endmodule

// File: rtl/jtpang_objdma.sv
// Object-RAM DMA: copies the object attribute table from CPU RAM into the video object buffer.
// Define JTPANG_OBJDMA_DBLBUF_EN for a double-buffered destination that flips bank per transfer.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int unsigned AW       = OBJ_TABLE_AW,
  parameter logic [11:0] SRC_BASE = OBJ_SRC_BASE
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cpu_cen,
  input  logic          dma_go,
  output logic          busrq,
  input  logic          busak_n,
  output logic [11:0]   src_addr,
  input  logic [7:0]    src_data,
`ifdef JTPANG_OBJDMA_DBLBUF_EN
  output logic [AW:0]   dst_addr,
`else
  output logic [AW-1:0] dst_addr,
`endif
  output logic [7:0]    dst_din,
  output logic          dst_we,
  output logic          busy,
  output logic          obj_bank
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'((1 << AW) - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  dma_state_t    state, state_d;
  logic [AW:0]   count, count_d;
  logic          busrq_d, busy_d;
  logic          issue_c, clr_pend_c;
  logic          go_edge_c, pending;
  logic          rd_pend;
  logic [AW-1:0] rd_idx;
`ifdef JTPANG_OBJDMA_DBLBUF_EN
  logic          flip_c;
  logic          bank;
`endif

  jtpang_objdma_edge u_edge (
    .rst       (rst),
    .clk       (clk),
    .cpu_cen   (cpu_cen),
    .dma_go    (dma_go),
    .busy      (busy),
    .clr       (clr_pend_c),
    .go_edge_c (go_edge_c),
    .pending   (pending)
  );

  // FSM state and bus handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      busrq <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      busrq <= busrq_d;
      busy  <= busy_d;
    end
  end

  // Next-state logic; every transition waits for cpu_cen
  always_comb begin
    state_d    = state;
    count_d    = count;
    busrq_d    = busrq;
    busy_d     = busy;
    issue_c    = 1'b0;
    clr_pend_c = 1'b0;
`ifdef JTPANG_OBJDMA_DBLBUF_EN
    flip_c     = 1'b0;
`endif
    if (cpu_cen) begin
      case (state)
        ST_IDLE: begin
          if (go_edge_c || pending) begin
            state_d    = ST_REQ;
            busrq_d    = 1'b1;
            busy_d     = 1'b1;
            clr_pend_c = pending;
          end
        end
        ST_REQ: begin
          if (!busak_n) begin
            state_d = ST_COPY;
            count_d = '0;
          end
        end
        ST_COPY: begin
          // A released bus freezes the counter; busrq stays up
          if (!busak_n) begin
            issue_c = 1'b1;
            count_d = count + ONE;
            if (count == LAST_IDX) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state_d = ST_IDLE;
          busrq_d = 1'b0;
          busy_d  = 1'b0;
`ifdef JTPANG_OBJDMA_DBLBUF_EN
          flip_c  = 1'b1;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read issue on cpu_cen, write one clk later once src_data has settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_addr <= SRC_BASE;
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_din  <= 8'd0;
    end else begin
      rd_pend <= issue_c;
      dst_we  <= rd_pend;
      if (issue_c) begin
        src_addr <= SRC_BASE + 12'(count);
        rd_idx   <= count[AW-1:0];
      end
      if (rd_pend) begin
`ifdef JTPANG_OBJDMA_DBLBUF_EN
        dst_addr <= {~bank, rd_idx};
`else
        dst_addr <= rd_idx;
`endif
        dst_din  <= src_data;
      end
    end
  end

`ifdef JTPANG_OBJDMA_DBLBUF_EN
  // Only completed transfers hand the freshly written bank to the video reader
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bank <= 1'b0;
    else if (flip_c) bank <= ~bank;
  end

  assign obj_bank = bank;
`else
  assign obj_bank = 1'b0;
`endif

endmodule
